uart_rx: RTL

//   Serial UART receiver, 8N1, LSB first, fixed BAUD derived from the bus clock.

---
 rtl/uart_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampling each bit at its midpoint.
// Received bytes land in a one-entry holding register with a valid/read handshake.
module uart_rx #(
    parameter int unsigned BUS_CLK = 40_000_000,
    parameter int unsigned BAUD    = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] din,
    output logic       valid,
    input  logic       read,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DivCount = BUS_CLK / BAUD;
    localparam int unsigned Half     = DivCount / 2;
    localparam int unsigned CntW     = $clog2(DivCount);
    localparam logic [CntW-1:0] CntLast = CntW'(DivCount - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      din_q, din_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic [1:0]      sync_fill_q;
    logic            cnt_last, cnt_half, deliver, stop_bad;

    assign cnt_last = (cnt_q == CntLast);
    assign cnt_half = (cnt_q == CntHalf);
    assign deliver  = (state_q == StStop) && cnt_last && rx_s_q;
    assign stop_bad = (state_q == StStop) && cnt_last && !rx_s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (rx_prev_q && !rx_s_q) state_d = StStart;
            StStart:    if (cnt_half) state_d = rx_s_q ? StIdle : StData;
            StData:     if (cnt_last && bit_idx_q == 3'd7) state_d = StStop;
            StStop:     if (cnt_last) state_d = rx_s_q ? StIdle : StWaitIdle;
            StWaitIdle: if (rx_s_q) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        din_d       = din_q;
        valid_d     = valid_q;
        frame_err_d = stop_bad;
        overrun_d   = deliver && valid_q && !read;
        if (state_d != state_q || state_q == StIdle || cnt_last) begin
            cnt_d = '0;
        end
        if (state_q != StData) begin
            bit_idx_d = 3'd0;
        end else if (cnt_last) begin
            bit_idx_d          = bit_idx_q + 3'd1;
            shift_d[bit_idx_q] = rx_s_q;
        end
        if (deliver) begin
            din_d   = shift_q;
            valid_d = 1'b1;
        end else if (read && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            din_q       <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b0;
            sync_fill_q <= 2'b00;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            din_q       <= din_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            // Ignore the synchroniser's reset-high values: only a real high line arms edge detect.
            rx_prev_q   <= sync_fill_q[1] & rx_s_q;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        din       = din_q;
        valid     = valid_q;
        frame_err = frame_err_q;
        overrun   = overrun_q;
    end

endmodule
